// File: rtl/cpu_mem_ram.sv
// cpu_mem_ram: 16x8 SAP RAM with run-mode bus access and a sequential byte loader.
// Define CPU_RAM_CHECKSUM_EN to keep the loader's mod-256 checksum on ld_sum.
module cpu_mem_ram (
  input  logic       clk,
  input  logic       rst,
  inout  wire  [7:0] bus,
  input  logic [3:0] address,
  input  logic       em,
  input  logic       lm,
  input  logic       prog,
  input  logic       ld_valid,
  input  logic [7:0] ld_data,
  output logic       ld_ready,
  output logic       ld_done,
  output logic [3:0] ld_addr,
  output logic [7:0] ld_sum
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_LOAD,
    S_DONE
  } state_t;

  state_t     r_state;
  logic [7:0] r_mem [16];
  logic [3:0] r_addr;
  logic       r_ready;
  logic       r_done;

  logic w_xfer;
  logic w_run_wr;
  logic w_rd;

  assign w_xfer   = r_ready && prog && ld_valid;
  assign w_run_wr = !prog && lm && !em;
  assign w_rd     = !prog && em;

  assign bus      = w_rd ? r_mem[address] : 8'bz;
  assign ld_ready = r_ready;
  assign ld_done  = r_done;
  assign ld_addr  = r_addr;

  // Storage has no reset so a loaded program survives a CPU reset.
  always_ff @(posedge clk) begin
    if (w_xfer)
      r_mem[r_addr] <= ld_data;
    else if (w_run_wr)
      r_mem[address] <= bus;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= S_IDLE;
      r_ready <= 1'b0;
      r_done  <= 1'b0;
      r_addr  <= 4'd0;
    end else begin
      unique case (r_state)
        S_IDLE: begin
          if (prog) begin
            r_state <= S_LOAD;
            r_ready <= 1'b1;
            r_addr  <= 4'd0;
          end
        end
        S_LOAD: begin
          if (!prog) begin
            r_state <= S_IDLE;
            r_ready <= 1'b0;
          end else if (ld_valid) begin
            r_addr <= r_addr + 4'd1;
            if (r_addr == 4'd15) begin
              r_state <= S_DONE;
              r_ready <= 1'b0;
              r_done  <= 1'b1;
            end
          end
        end
        S_DONE: begin
          if (!prog) begin
            r_state <= S_IDLE;
            r_done  <= 1'b0;
          end
        end
        default: begin
          r_state <= S_IDLE;
          r_ready <= 1'b0;
          r_done  <= 1'b0;
        end
      endcase
    end
  end

`ifdef CPU_RAM_CHECKSUM_EN
  logic [7:0] r_sum;

  always_ff @(posedge clk or posedge rst) begin
    if (rst)
      r_sum <= 8'h00;
    else if (r_state == S_IDLE && prog)
      r_sum <= 8'h00;
    else if (w_xfer)
      r_sum <= r_sum + ld_data;
  end

  assign ld_sum = r_sum;
`else
  assign ld_sum = 8'h00;
`endif

endmodule

// File: tb/tb_cpu_mem_ram.sv
// tb_cpu_mem_ram: directed tables plus random traffic for cpu_mem_ram.
// Expected values come from a byte-count model of the loader and a host copy of memory.
module tb_cpu_mem_ram;

  logic       clk = 1'b0;
  logic       rst;
  wire  [7:0] bus;
  logic [7:0] tb_bus;
  logic       tb_bus_en;
  logic [3:0] address;
  logic       em, lm, prog, ld_valid;
  logic [7:0] ld_data;
  logic       ld_ready, ld_done;
  logic [3:0] ld_addr;
  logic [7:0] ld_sum;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  assign bus = tb_bus_en ? tb_bus : 8'bz;

  cpu_mem_ram dut (
    .clk(clk), .rst(rst), .bus(bus), .address(address),
    .em(em), .lm(lm), .prog(prog), .ld_valid(ld_valid),
    .ld_data(ld_data), .ld_ready(ld_ready), .ld_done(ld_done),
    .ld_addr(ld_addr), .ld_sum(ld_sum)
  );

  // Reference: host memory copy, a load-session flag and a count of bytes taken.
  logic [7:0] m_mem [16];
  bit         m_sess;
  int         m_cnt;
  logic [7:0] m_sum;

  typedef struct {
    logic [7:0] data;
    logic       exp_ready;
    logic [3:0] exp_addr;
    logic       exp_done;
  } vec_t;

  vec_t tbl [17];

  task automatic chk(input string name, input logic [7:0] act,
                     input logic [7:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic model_reset();
    m_sess = 1'b0;
    m_cnt  = 0;
    m_sum  = 8'h00;
  endtask

  task automatic model_edge();
    if (!prog && lm && !em && tb_bus_en)
      m_mem[address] = tb_bus;
    if (rst) begin
      model_reset();
    end else if (!m_sess) begin
      if (prog) begin
        m_sess = 1'b1;
        m_cnt  = 0;
        m_sum  = 8'h00;
      end
    end else if (!prog) begin
      m_sess = 1'b0;
    end else if (ld_valid && m_cnt < 16) begin
      m_mem[m_cnt[3:0]] = ld_data;
      m_sum = m_sum + ld_data;
      m_cnt++;
    end
  endtask

  task automatic check_all(input string tag);
    logic [7:0] esum;
    logic       drv;
`ifdef CPU_RAM_CHECKSUM_EN
    esum = m_sum;
`else
    esum = 8'h00;
`endif
    drv = !prog && em;
    chk({tag, ".ready"}, 8'(ld_ready), 8'(m_sess && m_cnt < 16));
    chk({tag, ".done"}, 8'(ld_done), 8'(m_sess && m_cnt == 16));
    chk({tag, ".addr"}, 8'(ld_addr), 8'(m_cnt[3:0]));
    chk({tag, ".sum"}, ld_sum, esum);
    if (drv && !tb_bus_en)
      chk({tag, ".bus_rd"}, bus, m_mem[address]);
    else if (!drv && tb_bus_en)
      chk({tag, ".bus_z"}, bus, tb_bus);
  endtask

  // Entered and left at posedge+1; checks at the falling edge.
  task automatic cycle(input string tag);
    @(negedge clk);
    check_all(tag);
    model_edge();
    @(posedge clk);
    #1;
  endtask

  task automatic readback(input string tag);
    prog = 1'b0; ld_valid = 1'b0; lm = 1'b0; em = 1'b1;
    tb_bus_en = 1'b0;
    for (int i = 0; i < 16; i++) begin
      address = i[3:0];
      cycle(tag);
    end
    em = 1'b0; tb_bus_en = 1'b1; tb_bus = 8'h00;
  endtask

  initial begin
    int n;
    rst = 1'b1; prog = 1'b0; em = 1'b0; lm = 1'b0; address = 4'd0;
    ld_valid = 1'b0; ld_data = 8'h00; tb_bus = 8'h00; tb_bus_en = 1'b1;
    model_reset();
    for (int i = 0; i < 16; i++) m_mem[i] = 8'h00;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;

    // Seed every word so later reads are known.
    lm = 1'b1;
    for (int i = 0; i < 16; i++) begin
      address = i[3:0];
      tb_bus  = 8'hC0 + 8'(i);
      cycle("fill");
    end
    lm = 1'b0; tb_bus = 8'h00;
    rst = 1'b1;
    cycle("rst");
    rst = 1'b0;

    // Contents survive reset.
    address = 4'd3; em = 1'b1; tb_bus_en = 1'b0;
    #1;
    chk("pre_reset_word3", bus, 8'hC3);
    cycle("rd3");
    em = 1'b0; tb_bus_en = 1'b1; tb_bus = 8'h00;
    #1;
    chk("bus_z_idle", bus, 8'h00);
    chk("ready_reset", 8'(ld_ready), 8'h00);
    chk("done_reset", 8'(ld_done), 8'h00);
    cycle("idle");

    // Run-mode write, then em+lm conflict must not write.
    address = 4'd7; tb_bus = 8'hA5; lm = 1'b1;
    cycle("wr7");
    lm = 1'b0; em = 1'b1; tb_bus_en = 1'b0;
    #1;
    chk("run_write_word7", bus, 8'hA5);
    cycle("rd7");
    lm = 1'b1; tb_bus_en = 1'b1; tb_bus = 8'h3C;
    cycle("emlm");
    lm = 1'b0; tb_bus_en = 1'b0;
    #1;
    chk("no_self_write_word7", bus, 8'hA5);
    cycle("rd7b");
    em = 1'b0; tb_bus_en = 1'b1; tb_bus = 8'h00;

    // Full load from a table of expected handshake states.
    for (int i = 0; i < 16; i++) begin
      tbl[i].data      = 8'h10 + 8'(i);
      tbl[i].exp_ready = 1'b1;
      tbl[i].exp_addr  = i[3:0];
      tbl[i].exp_done  = 1'b0;
    end
    tbl[16].data      = 8'hEE;
    tbl[16].exp_ready = 1'b0;
    tbl[16].exp_addr  = 4'd0;
    tbl[16].exp_done  = 1'b1;

    prog = 1'b1;
    #1;
    chk("ready_before_load", 8'(ld_ready), 8'h00);
    cycle("enter");
    ld_valid = 1'b1;
    for (int i = 0; i < 17; i++) begin
      ld_data = tbl[i].data;
      #1;
      chk($sformatf("tbl%0d.ready", i), 8'(ld_ready), 8'(tbl[i].exp_ready));
      chk($sformatf("tbl%0d.addr", i), 8'(ld_addr), 8'(tbl[i].exp_addr));
      chk($sformatf("tbl%0d.done", i), 8'(ld_done), 8'(tbl[i].exp_done));
      cycle("load");
    end
`ifdef CPU_RAM_CHECKSUM_EN
    chk("checksum_full", ld_sum, 8'h78);
`else
    chk("checksum_off", ld_sum, 8'h00);
`endif
    prog = 1'b0; ld_valid = 1'b0;
    cycle("exit");
    #1;
    chk("done_fall", 8'(ld_done), 8'h00);
    em = 1'b1; tb_bus_en = 1'b0;
    for (int i = 0; i < 16; i++) begin
      address = i[3:0];
      #1;
      chk($sformatf("load_word%0d", i), bus, 8'h10 + 8'(i));
      cycle("rdload");
    end
    em = 1'b0; tb_bus_en = 1'b1; tb_bus = 8'h00;

    // Gapped handshake, then valid traffic while done.
    prog = 1'b1;
    cycle("gap_enter");
    n = 0;
    while (m_cnt < 16 && n < 60) begin
      ld_valid = n[0];
      ld_data  = 8'($urandom);
      cycle("gap");
      n++;
    end
    chk("gap_finished", 8'(m_cnt == 16), 8'h01);
    ld_valid = 1'b1;
    repeat (3) begin
      ld_data = 8'($urandom);
      cycle("done_valid");
    end
    readback("gap_rd");

    // Abort after five bytes, then re-enter.
    prog = 1'b1;
    cycle("ab_enter");
    ld_valid = 1'b1;
    repeat (5) begin
      ld_data = 8'($urandom);
      cycle("ab_load");
    end
    prog = 1'b0; ld_data = 8'hFF;
    cycle("ab_drop");
    chk("abort_addr_kept", 8'(ld_addr), 8'h05);
    readback("ab_rd");
    prog = 1'b1;
    cycle("re_enter");
    #1;
    chk("reenter_addr0", 8'(ld_addr), 8'h00);
    chk("reenter_ready", 8'(ld_ready), 8'h01);

    // Async reset after nine bytes.
    ld_valid = 1'b1;
    repeat (9) begin
      ld_data = 8'($urandom);
      cycle("ar_load");
    end
    #1;
    rst = 1'b1;
    #1;
    chk("async_ready", 8'(ld_ready), 8'h00);
    chk("async_addr", 8'(ld_addr), 8'h00);
    model_reset();
    prog = 1'b0; ld_valid = 1'b0;
    cycle("ar_hold");
    rst = 1'b0;
    readback("ar_rd");

    // Random mixed traffic.
    for (int k = 0; k < 400; k++) begin
      if ($urandom_range(0, 9) == 0) prog = ~prog;
      ld_valid = 1'($urandom);
      ld_data  = 8'($urandom);
      address  = 4'($urandom);
      em       = 1'($urandom);
      lm       = 1'($urandom);
      if (!prog && em) begin
        tb_bus_en = 1'b0;
      end else begin
        tb_bus_en = 1'b1;
        tb_bus    = lm ? 8'($urandom) : 8'h00;
      end
      cycle("rand");
    end
    readback("final_rd");

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
